if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage that fetches FETCH_WIDTH consecutive instructions per cycle from instruction memory into a circular instruction queue and presents one instruction per cycle to ID. It replaces the single-instruction fetch register: the queue decouples IM fetch from ID stalls, and a redirect (branch/jump) flushes the queue and restarts fetch at the alternate PC. It sits between the instruction memory port and ID, with the same outward contract toward ID plus a valid flag.

## Interface
- FETCH_WIDTH, 2: instructions per IM access; legal values 1, 2, 4.
- QUEUE_DEPTH, 8: queue entries; power of 2, ≥ 2·FETCH_WIDTH.
- RESET_PC, 32'hBFC00000: first fetch address after reset.

- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  ID cannot accept an instruction this cycle.
- Request_Alt_PC  in  1  redirect request; honoured only when STALL=0.
- Alt_PC  in  32  redirect target; bits [1:0] ignored (treated as 0).
- Instr_address_2IM  out  32  word-aligned address of first word of this cycle's fetch group.
- Instr_req_2IM  out  1  fetch group is consumed at the next edge.
- Instr_fIM  in  32·FETCH_WIDTH  IM data, combinational; word k (bits 32k+31:32k) is the instruction at address+4k.
- Instr1_OUT  out  32  queue-head instruction; 0 when not valid.
- Instr_PC_OUT  out  32  address of Instr1_OUT; 0 when not valid.
- Instr_PC_Plus4  out  32  Instr_PC_OUT+4; 0 when not valid.
- Instr_Valid_OUT  out  1  Instr1_OUT holds a real instruction.

## Operation
- State: fetch_pc[31:0], head/tail pointers (log2(QUEUE_DEPTH) bits, wrap modulo QUEUE_DEPTH), count (log2(QUEUE_DEPTH)+1 bits), per-entry {instr, pc}.
- Reset: fetch_pc=RESET_PC, head=tail=count=0; all outputs 0, Instr_req_2IM=0 while RESET low.
- Redirect cycle (Request_Alt_PC=1, STALL=0): Instr_address_2IM=Alt_PC&~3, Instr_req_2IM=1; at edge queue flushed (count, head, tail cleared), group from Alt_PC written to entries 0..FETCH_WIDTH-1, count=FETCH_WIDTH, fetch_pc=Alt_PC+4·FETCH_WIDTH. Current head is discarded, not popped.
- Normal cycle: Instr_address_2IM=fetch_pc; Instr_req_2IM=1 iff (QUEUE_DEPTH−count) ≥ FETCH_WIDTH, evaluated on current count, ignoring a same-cycle pop. When requested: group written at tail..tail+FETCH_WIDTH−1 (wrapping), tail += FETCH_WIDTH, fetch_pc += 4·FETCH_WIDTH.
- Pop: when Instr_Valid_OUT=1 and STALL=0 and no redirect, head advances by 1, count −1.
- Push and pop in one cycle: count += FETCH_WIDTH−1.
- Request_Alt_PC while STALL=1: ignored; ID holds the request until STALL drops. No push-gating changes; fetch continues if space allows.
- fetch_pc wraps modulo 2^32 with no error.
- Reset asserted mid-operation: immediate return to reset state, queue contents lost.

## Timing
- Combinational: outputs from queue head (or bypass path); Instr_address_2IM/Instr_req_2IM from fetch_pc, count, Request_Alt_PC, STALL.
- Fetch-to-ID latency (no bypass): instruction fetched at edge N is presented at earliest in cycle N+1.
- Redirect penalty (no bypass): Instr_Valid_OUT=0 in the redirect cycle's successor only if queue was refilled late; with redirect refill it is 1 in cycle N+1 with PC=Alt_PC.
- Sustained throughput: 1 instruction/cycle to ID whenever FETCH_WIDTH ≥ 1 and STALL=0.

## Configuration
- IF_QUEUE_BYPASS_EN defined: when count=0 and no redirect and Instr_req_2IM=1, head outputs come directly from IM word 0 (PC=fetch_pc), Instr_Valid_OUT=1 same cycle; if popped, only words 1..FETCH_WIDTH−1 are written (count += FETCH_WIDTH−1).
- Undefined: Instr_Valid_OUT=0 whenever count=0; no combinational path from Instr_fIM to outputs.

## Test plan
- Reset release, STALL=0, FETCH_WIDTH=2, DEPTH=8: addresses BFC00000, BFC00008, … ; Instr_PC_OUT from cycle 1 = BFC00000, BFC00004, BFC00008 consecutively, Instr_PC_Plus4 = PC+4.
- STALL=1 held 10 cycles from reset: pushes at BFC00000..BFC00018 (4 groups), then Instr_req_2IM=0, count=8, head PC stays BFC00000; release → pops in order, fetch resumes at BFC00020 once 2 slots free.
- Redirect Alt_PC=0x00400013 with 5 entries queued: next cycle count=2, Instr_PC_OUT=0x00400010, then 0x00400014, next fetch 0x00400018.
- Request_Alt_PC=1 with STALL=1 for 3 cycles, then STALL=0: redirect applied only on the STALL=0 edge; no popped instruction during stall.
- Wrap: DEPTH=8, 20 instructions streamed with alternating STALL: output PC sequence strictly +4, no loss/duplication across pointer wrap; fetch_pc 0xFFFFFFF8 → 0x00000000.
- RESET low while count=6: all outputs 0 immediately; after release first address BFC00000. With IF_QUEUE_BYPASS_EN: Instr_Valid_OUT=1, Instr_PC_OUT=BFC00000 in the first cycle after release.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: IM request/data plus the ID-facing instruction outputs and stall/redirect inputs.
// The master modport is the fetch queue; the slave modport is the IM/ID side.
interface if_fetch_queue_if #(
  parameter int FETCH_WIDTH = 2
) ();
  logic                       STALL;
  logic                       Request_Alt_PC;
  logic [31:0]                Alt_PC;
  logic [31:0]                Instr_address_2IM;
  logic                       Instr_req_2IM;
  logic [32*FETCH_WIDTH-1:0]  Instr_fIM;
  logic [31:0]                Instr1_OUT;
  logic [31:0]                Instr_PC_OUT;
  logic [31:0]                Instr_PC_Plus4;
  logic                       Instr_Valid_OUT;

  modport master (
    input  STALL, Request_Alt_PC, Alt_PC, Instr_fIM,
    output Instr_address_2IM, Instr_req_2IM,
    output Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Instr_Valid_OUT
  );

  modport slave (
    output STALL, Request_Alt_PC, Alt_PC, Instr_fIM,
    input  Instr_address_2IM, Instr_req_2IM,
    input  Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Instr_Valid_OUT
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: FETCH_WIDTH-wide IM fetch into a circular queue, one instruction per cycle to ID.
// Optional macro IF_QUEUE_BYPASS_EN: an empty queue forwards IM word 0 straight to the ID outputs.
module if_fetch_queue #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'hBFC00000
) (
  input  logic             CLK,
  input  logic             RESET,
  if_fetch_queue_if.master bus
);

  localparam int          PTR_W       = $clog2(QUEUE_DEPTH);
  localparam int          CNT_W       = PTR_W + 1;
  localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_WIDTH);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0]      q_instr [QUEUE_DEPTH];
  logic [31:0]      q_pc    [QUEUE_DEPTH];

  logic             redirect;
  logic             req;
  logic             bypass;
  logic             valid;
  logic             pop;
  logic             pop_q;
  logic [31:0]      alt_pc_al;
  logic [31:0]      group_pc;
  logic [31:0]      head_instr;
  logic [31:0]      head_pc;
  logic [CNT_W-1:0] space;
  logic [CNT_W-1:0] push_n;

  logic             wr_en  [FETCH_WIDTH];
  logic [PTR_W-1:0] wr_idx [FETCH_WIDTH];

  // Fetch request: a redirect always fetches; otherwise only when a whole group fits.
  assign alt_pc_al = bus.Alt_PC & 32'hFFFF_FFFC;
  assign redirect  = RESET & bus.Request_Alt_PC & ~bus.STALL;
  assign space     = CNT_W'(QUEUE_DEPTH) - count;
  assign req       = RESET & (redirect | (space >= CNT_W'(FETCH_WIDTH)));
  assign group_pc  = redirect ? alt_pc_al : fetch_pc;

`ifdef IF_QUEUE_BYPASS_EN
  assign bypass = (count == '0) & ~redirect & req;
`else
  assign bypass = 1'b0;
`endif

  // Queue head (or bypassed IM word 0) toward ID.
  assign valid      = (count != '0) | bypass;
  assign head_instr = bypass ? bus.Instr_fIM[31:0] : q_instr[head];
  assign head_pc    = bypass ? fetch_pc : q_pc[head];
  assign pop        = valid & ~bus.STALL & ~redirect;
  assign pop_q      = pop & ~bypass;

  assign bus.Instr_address_2IM = RESET ? group_pc : 32'h0;
  assign bus.Instr_req_2IM     = req;
  assign bus.Instr_Valid_OUT   = valid;
  assign bus.Instr1_OUT        = valid ? head_instr : 32'h0;
  assign bus.Instr_PC_OUT      = valid ? head_pc : 32'h0;
  assign bus.Instr_PC_Plus4    = valid ? head_pc + 32'd4 : 32'h0;

  always_comb begin
    push_n = '0;
    if (req && !redirect) begin
      push_n = (bypass && pop) ? CNT_W'(FETCH_WIDTH - 1) : CNT_W'(FETCH_WIDTH);
    end
  end

  // A bypassed-and-consumed word 0 is not stored; the rest of the group shifts down one slot.
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_en[k]  = 1'b0;
      wr_idx[k] = '0;
      if (redirect) begin
        wr_en[k]  = 1'b1;
        wr_idx[k] = PTR_W'(k);
      end else if (req) begin
        if (bypass && pop) begin
          wr_en[k]  = (k != 0);
          wr_idx[k] = tail + PTR_W'(k) - PTR_W'(1);
        end else begin
          wr_en[k]  = 1'b1;
          wr_idx[k] = tail + PTR_W'(k);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (wr_en[k]) begin
        q_instr[wr_idx[k]] <= bus.Instr_fIM[32*k +: 32];
        q_pc[wr_idx[k]]    <= group_pc + 32'(4 * k);
      end
    end
  end

  // Control state: a redirect flushes the queue and restarts it from slot 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= alt_pc_al + GROUP_BYTES;
      head     <= '0;
      tail     <= PTR_W'(FETCH_WIDTH);
      count    <= CNT_W'(FETCH_WIDTH);
    end else begin
      if (req) begin
        fetch_pc <= fetch_pc + GROUP_BYTES;
      end
      head  <= head + PTR_W'(pop_q);
      tail  <= tail + push_n[PTR_W-1:0];
      count <= count + push_n - CNT_W'(pop_q);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (FETCH_WIDTH=2, QUEUE_DEPTH=8, default build without bypass).
// IM returns addr ^ 32'h5A5A5A5A for every word, so the expected instruction follows from its PC.
module tb_if_fetch_queue;

  localparam int          FW = 2;
  localparam int          QD = 8;
  localparam logic [31:0] B  = 32'hBFC00000;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  if_fetch_queue_if #(.FETCH_WIDTH(FW)) bus ();

  if_fetch_queue #(
    .FETCH_WIDTH(FW),
    .QUEUE_DEPTH(QD),
    .RESET_PC(B)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus.master)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  for (genvar k = 0; k < FW; k++) begin : g_im
    assign bus.Instr_fIM[32*k +: 32] = imem(bus.Instr_address_2IM + 32'(4 * k));
  end

  typedef struct {
    bit          rst;
    bit          stall;
    bit          ra;
    logic [31:0] alt;
    bit          ev;
    logic [31:0] epc;
    bit          ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit stall, input bit ra, input logic [31:0] alt,
                     input bit ev, input logic [31:0] epc, input bit ereq, input logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.stall = stall; v.ra = ra; v.alt = alt;
    v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    bus.STALL = 1'b0;
    bus.Request_Alt_PC = 1'b0;
    bus.Alt_PC = 32'h0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  task automatic chk_head(input string tag, input bit ev, input logic [31:0] epc);
    chk({tag, "_valid"}, 32'(bus.Instr_Valid_OUT), 32'(ev));
    chk({tag, "_pc"},    bus.Instr_PC_OUT,   ev ? epc : 32'h0);
    chk({tag, "_plus4"}, bus.Instr_PC_Plus4, ev ? epc + 32'd4 : 32'h0);
    chk({tag, "_instr"}, bus.Instr1_OUT,     ev ? imem(epc) : 32'h0);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_addr;
  int          pops;

  initial begin
    bus.STALL = 1'b0;
    bus.Request_Alt_PC = 1'b0;
    bus.Alt_PC = 32'h0;

    // Free-running stream from reset.
    add(1, 0, 0, 0, 0, 0,         1, B);
    add(0, 0, 0, 0, 1, B,         1, B + 32'h08);
    add(0, 0, 0, 0, 1, B + 32'h04, 1, B + 32'h10);
    add(0, 0, 0, 0, 1, B + 32'h08, 1, B + 32'h18);
    add(0, 0, 0, 0, 1, B + 32'h0C, 1, B + 32'h20);
    add(0, 0, 0, 0, 1, B + 32'h10, 1, B + 32'h28);
    add(0, 0, 0, 0, 1, B + 32'h14, 0, B + 32'h30);
    add(0, 0, 0, 0, 1, B + 32'h18, 1, B + 32'h30);
    add(0, 0, 0, 0, 1, B + 32'h1C, 0, B + 32'h38);
    // Stall from reset until full, then drain.
    add(1, 1, 0, 0, 0, 0,         1, B);
    add(0, 1, 0, 0, 1, B,         1, B + 32'h08);
    add(0, 1, 0, 0, 1, B,         1, B + 32'h10);
    add(0, 1, 0, 0, 1, B,         1, B + 32'h18);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 1, B, 0, B + 32'h20);
    add(0, 0, 0, 0, 1, B,         0, B + 32'h20);
    add(0, 0, 0, 0, 1, B + 32'h04, 0, B + 32'h20);
    add(0, 0, 0, 0, 1, B + 32'h08, 1, B + 32'h20);
    add(0, 0, 0, 0, 1, B + 32'h0C, 0, B + 32'h28);
    add(0, 0, 0, 0, 1, B + 32'h10, 1, B + 32'h28);
    // Redirect to an unaligned target with 5 entries queued.
    add(1, 1, 0, 0,            0, 0,            1, B);
    add(0, 1, 0, 0,            1, B,            1, B + 32'h08);
    add(0, 0, 0, 0,            1, B,            1, B + 32'h10);
    add(0, 0, 1, 32'h00400013, 1, B + 32'h04,   1, 32'h00400010);
    add(0, 0, 0, 0,            1, 32'h00400010, 1, 32'h00400018);
    add(0, 0, 0, 0,            1, 32'h00400014, 1, 32'h00400020);
    add(0, 0, 0, 0,            1, 32'h00400018, 1, 32'h00400028);
    // Redirect held under stall is applied only once STALL drops.
    add(1, 1, 1, 32'h00001000, 0, 0,            1, B);
    add(0, 1, 1, 32'h00001000, 1, B,            1, B + 32'h08);
    add(0, 1, 1, 32'h00001000, 1, B,            1, B + 32'h10);
    add(0, 0, 1, 32'h00001000, 1, B,            1, 32'h00001000);
    add(0, 0, 0, 0,            1, 32'h00001000, 1, 32'h00001008);
    add(0, 0, 0, 0,            1, 32'h00001004, 1, 32'h00001010);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      bus.STALL          = vecs[i].stall;
      bus.Request_Alt_PC = vecs[i].ra;
      bus.Alt_PC         = vecs[i].alt;
      @(negedge CLK);
      chk_head($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc);
      chk($sformatf("v%0d_req", i),  32'(bus.Instr_req_2IM), 32'(vecs[i].ereq));
      chk($sformatf("v%0d_addr", i), bus.Instr_address_2IM, vecs[i].eaddr);
      @(posedge CLK);
      #1;
    end

    // Pointer and fetch_pc wrap: stream 20 instructions from near the top of the address space.
    do_reset();
    bus.Request_Alt_PC = 1'b1;
    bus.Alt_PC = 32'hFFFF_FFE1;
    @(negedge CLK);
    chk("wrap_redirect_addr", bus.Instr_address_2IM, 32'hFFFF_FFE0);
    @(posedge CLK);
    #1;
    bus.Request_Alt_PC = 1'b0;
    exp_pc   = 32'hFFFF_FFE0;
    exp_addr = 32'hFFFF_FFE8;
    pops     = 0;
    for (int cyc = 0; cyc < 80 && pops < 20; cyc++) begin
      bus.STALL = (cyc % 3 == 1);
      @(negedge CLK);
      if (bus.Instr_req_2IM) begin
        chk($sformatf("wrap_addr_c%0d", cyc), bus.Instr_address_2IM, exp_addr);
        exp_addr = exp_addr + 32'd8;
      end
      if (bus.Instr_Valid_OUT && !bus.STALL) begin
        chk($sformatf("wrap_pc_%0d", pops),    bus.Instr_PC_OUT,   exp_pc);
        chk($sformatf("wrap_plus4_%0d", pops), bus.Instr_PC_Plus4, exp_pc + 32'd4);
        chk($sformatf("wrap_instr_%0d", pops), bus.Instr1_OUT,     imem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      @(posedge CLK);
      #1;
    end
    chk("wrap_pop_count", 32'(pops), 32'd20);
    chk("wrap_fetch_crossed_zero", 32'(exp_addr > 32'h0000_0010 && exp_addr < 32'h1000_0000), 32'd1);

    // Asynchronous reset while six entries are queued.
    do_reset();
    bus.STALL = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_head("prerst", 1'b1, B);
    RESET = 1'b0;
    #1;
    chk_head("midrst", 1'b0, 32'h0);
    chk("midrst_req",  32'(bus.Instr_req_2IM), 32'd0);
    chk("midrst_addr", bus.Instr_address_2IM, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    bus.STALL = 1'b0;
    @(negedge CLK);
    chk_head("postrst0", 1'b0, 32'h0);
    chk("postrst0_addr", bus.Instr_address_2IM, B);
    chk("postrst0_req",  32'(bus.Instr_req_2IM), 32'd1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk_head("postrst1", 1'b1, B);
    chk("postrst1_addr", bus.Instr_address_2IM, B + 32'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
